rmt_cmd_sequencer: RTL

Programmable command sequencer for the RemoteComm host side. It replaces hand-written send/wait/check code with one reusable block. A buffer of DEPTH {cmd, expected-resp} entries is loaded, then run in order. For each entry the block pulses snd_cmd, waits for cmd_snt and resp_rdy under a per-command cycle timeout, and compares resp. It reports pass/fail with the failing index and cause. It sits between test or host control logic and RemoteComm, which is instantiated outside this block.

---
 rtl/rmt_seq_pkg.sv | 29 ++
 rtl/rmt_seq_buf.sv | 51 +++++
 rtl/rmt_cmd_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rmt_seq_pkg.sv
// Shared types and constants for the RemoteComm command sequencer.
package rmt_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_SNT,
    S_WAIT_RESP,
    S_CHECK,
    S_FIN
  } seq_state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_TMO   = 2'b01;
  localparam logic [1:0] ERR_RESP  = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  localparam logic [7:0] RESP_POS_ACK = 8'hA5;

  localparam int SEQ_CMD_W  = 16;
  localparam int SEQ_RESP_W = 8;

  // Entry layout for the default 16-bit command / 8-bit response configuration.
  typedef struct packed {
    logic [SEQ_CMD_W-1:0]  cmd;
    logic [SEQ_RESP_W-1:0] resp;
  } seq_entry_t;

endpackage

// File: rtl/rmt_seq_buf.sv
// Command/expected-response buffer: append-only write pointer, clear, and
// combinational read by index.
module rmt_seq_buf #(
  parameter  int DEPTH  = 8,
  parameter  int CMD_W  = 16,
  parameter  int RESP_W = 8,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CMD_W-1:0]  wr_cmd,
  input  logic [RESP_W-1:0] wr_resp,
  input  logic              clr,
  input  logic [IW-1:0]     rd_idx,
  output logic [CMD_W-1:0]  rd_cmd,
  output logic [RESP_W-1:0] rd_resp,
  output logic [CW-1:0]     count,
  output logic              full
);

  logic [CMD_W-1:0]  cmd_mem  [DEPTH];
  logic [RESP_W-1:0] resp_mem [DEPTH];
  logic              wr_ok;

  assign full  = (count == CW'(DEPTH));
  assign wr_ok = wr_en && !full && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (wr_ok) begin
      count <= count + CW'(1);
    end
  end

  // NOTE: storage has no reset; contents are meaningless until count covers them.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      cmd_mem[count[IW-1:0]]  <= wr_cmd;
      resp_mem[count[IW-1:0]] <= wr_resp;
    end
  end

  assign rd_cmd  = cmd_mem[rd_idx];
  assign rd_resp = resp_mem[rd_idx];

endmodule

// File: rtl/rmt_cmd_sequencer.sv
// Runs a loaded list of {cmd, expected resp} through RemoteComm, one at a time,
// with a per-command timeout, and reports pass/fail with index and cause.
module rmt_cmd_sequencer
  import rmt_seq_pkg::*;
#(
  parameter  int DEPTH   = 8,
  parameter  int CMD_W   = 16,
  parameter  int RESP_W  = 8,
  parameter  int TMO_W   = 24,
  parameter  int TMO_CYC = 10000000,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int IW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CMD_W-1:0]  wr_cmd,
  input  logic [RESP_W-1:0] wr_resp,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  output logic [CMD_W-1:0]  cmd,
  output logic              snd_cmd,
  input  logic              cmd_snt,
  input  logic              resp_rdy,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              full,
  output logic [CW-1:0]     count,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [IW-1:0]     err_idx,
  output logic [1:0]        err_code,
  output logic [CW-1:0]     n_ok
);

  seq_state_t        state, state_nxt;
  logic [IW-1:0]     idx, rd_idx;
  logic [CMD_W-1:0]  rd_cmd;
  logic [RESP_W-1:0] rd_resp, exp_resp, got_resp;
  logic [TMO_W-1:0]  timer;
  logic              idle, tmo_hit, last_entry;
  logic              ld_cmd, latch_resp, set_pass, set_fail, inc_ok, clr_res;
  logic [1:0]        fail_code;

  assign idle       = (state == S_IDLE);
  assign busy       = (state != S_IDLE) && (state != S_FIN);
  assign done       = (state == S_FIN);
  assign snd_cmd    = (state == S_SEND) && !abort;
  assign tmo_hit    = (timer == TMO_W'(TMO_CYC - 1));
  assign last_entry = (CW'(idx) + CW'(1) == count);

  rmt_seq_buf #(.DEPTH(DEPTH), .CMD_W(CMD_W), .RESP_W(RESP_W)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en && idle),
    .wr_cmd  (wr_cmd),
    .wr_resp (wr_resp),
    .clr     (clr && idle),
    .rd_idx  (rd_idx),
    .rd_cmd  (rd_cmd),
    .rd_resp (rd_resp),
    .count   (count),
    .full    (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    rd_idx     = idx;
    ld_cmd     = 1'b0;
    latch_resp = 1'b0;
    set_pass   = 1'b0;
    set_fail   = 1'b0;
    fail_code  = ERR_NONE;
    inc_ok     = 1'b0;
    clr_res    = idle && (start || clr);
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (count == '0) begin
            set_pass  = 1'b1;
            state_nxt = S_FIN;
          end else begin
            rd_idx    = '0;
            ld_cmd    = 1'b1;
            state_nxt = S_SEND;
          end
        end
      end
      S_SEND: state_nxt = S_WAIT_SNT;
      S_WAIT_SNT, S_WAIT_RESP: begin
        if (resp_rdy) begin
          latch_resp = 1'b1;
          state_nxt  = S_CHECK;
        end else if (tmo_hit) begin
          set_fail  = 1'b1;
          fail_code = ERR_TMO;
          state_nxt = S_FIN;
        end else if (state == S_WAIT_SNT && cmd_snt) begin
          state_nxt = S_WAIT_RESP;
        end
      end
      S_CHECK: begin
        if (got_resp != exp_resp) begin
          set_fail  = 1'b1;
          fail_code = ERR_RESP;
          state_nxt = S_FIN;
        end else begin
          inc_ok = 1'b1;
          if (last_entry) begin
            set_pass  = 1'b1;
            state_nxt = S_FIN;
          end else begin
            rd_idx    = idx + IW'(1);
            ld_cmd    = 1'b1;
            state_nxt = S_SEND;
          end
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort overrides whatever the current state decided.
    if (busy && abort) begin
      ld_cmd     = 1'b0;
      latch_resp = 1'b0;
      set_pass   = 1'b0;
      inc_ok     = 1'b0;
      set_fail   = 1'b1;
      fail_code  = ERR_ABORT;
      state_nxt  = S_FIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      cmd      <= '0;
      exp_resp <= '0;
      got_resp <= '0;
      timer    <= '0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      err_idx  <= '0;
      err_code <= ERR_NONE;
      n_ok     <= '0;
    end else begin
      // Timer is zeroed on entry to SEND so done lands TMO_CYC cycles after snd_cmd.
      if (ld_cmd) begin
        idx      <= rd_idx;
        cmd      <= rd_cmd;
        exp_resp <= rd_resp;
        timer    <= '0;
      end else if (busy) begin
        timer <= timer + TMO_W'(1);
      end
      if (latch_resp) got_resp <= resp;
      if (clr_res) begin
        pass     <= 1'b0;
        fail     <= 1'b0;
        err_idx  <= '0;
        err_code <= ERR_NONE;
        n_ok     <= '0;
      end
      if (inc_ok)   n_ok <= n_ok + CW'(1);
      if (set_pass) pass <= 1'b1;
      if (set_fail) begin
        fail     <= 1'b1;
        err_code <= fail_code;
        err_idx  <= idx;
      end
    end
  end

endmodule
